// File: rtl/sort.sv
`default_nettype none
// ============================================================================
//  Module      : sort
//  Description : Iterative 32-entry bubble sorter for 7-bit unsigned values.
//                One compare-and-swap per clock, ascending order, with a
//                start/ack handshake toward the producer and the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module sort (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ack,
    input  logic [6:0] a0,
    input  logic [6:0] a1,
    input  logic [6:0] a2,
    input  logic [6:0] a3,
    input  logic [6:0] a4,
    input  logic [6:0] a5,
    input  logic [6:0] a6,
    input  logic [6:0] a7,
    input  logic [6:0] a8,
    input  logic [6:0] a9,
    input  logic [6:0] a10,
    input  logic [6:0] a11,
    input  logic [6:0] a12,
    input  logic [6:0] a13,
    input  logic [6:0] a14,
    input  logic [6:0] a15,
    input  logic [6:0] a16,
    input  logic [6:0] a17,
    input  logic [6:0] a18,
    input  logic [6:0] a19,
    input  logic [6:0] a20,
    input  logic [6:0] a21,
    input  logic [6:0] a22,
    input  logic [6:0] a23,
    input  logic [6:0] a24,
    input  logic [6:0] a25,
    input  logic [6:0] a26,
    input  logic [6:0] a27,
    input  logic [6:0] a28,
    input  logic [6:0] a29,
    input  logic [6:0] a30,
    input  logic [6:0] a31,
    output logic [6:0] b0,
    output logic [6:0] b1,
    output logic [6:0] b2,
    output logic [6:0] b3,
    output logic [6:0] b4,
    output logic [6:0] b5,
    output logic [6:0] b6,
    output logic [6:0] b7,
    output logic [6:0] b8,
    output logic [6:0] b9,
    output logic [6:0] b10,
    output logic [6:0] b11,
    output logic [6:0] b12,
    output logic [6:0] b13,
    output logic [6:0] b14,
    output logic [6:0] b15,
    output logic [6:0] b16,
    output logic [6:0] b17,
    output logic [6:0] b18,
    output logic [6:0] b19,
    output logic [6:0] b20,
    output logic [6:0] b21,
    output logic [6:0] b22,
    output logic [6:0] b23,
    output logic [6:0] b24,
    output logic [6:0] b25,
    output logic [6:0] b26,
    output logic [6:0] b27,
    output logic [6:0] b28,
    output logic [6:0] b29,
    output logic [6:0] b30,
    output logic [6:0] b31
);

    // First pass covers compares 0..30 (31 adjacent pairs)
    localparam logic [4:0] C_LIM_INIT = 5'd31;

    typedef enum logic [1:0] {
        ST_INI  = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] arr_q [32];
    logic [6:0] arr_d [32];
    logic [4:0] i_q, i_d;
    logic [4:0] lim_q, lim_d;
    logic       sw_q, sw_d;

    logic [6:0] w_a [32];
    logic [4:0] w_ip1;
    logic [4:0] w_last;
    logic [6:0] w_lo;
    logic [6:0] w_hi;
    logic       w_swap;

    // Gather the flat input ports into an indexable array
    assign w_a[0]  = a0;
    assign w_a[1]  = a1;
    assign w_a[2]  = a2;
    assign w_a[3]  = a3;
    assign w_a[4]  = a4;
    assign w_a[5]  = a5;
    assign w_a[6]  = a6;
    assign w_a[7]  = a7;
    assign w_a[8]  = a8;
    assign w_a[9]  = a9;
    assign w_a[10] = a10;
    assign w_a[11] = a11;
    assign w_a[12] = a12;
    assign w_a[13] = a13;
    assign w_a[14] = a14;
    assign w_a[15] = a15;
    assign w_a[16] = a16;
    assign w_a[17] = a17;
    assign w_a[18] = a18;
    assign w_a[19] = a19;
    assign w_a[20] = a20;
    assign w_a[21] = a21;
    assign w_a[22] = a22;
    assign w_a[23] = a23;
    assign w_a[24] = a24;
    assign w_a[25] = a25;
    assign w_a[26] = a26;
    assign w_a[27] = a27;
    assign w_a[28] = a28;
    assign w_a[29] = a29;
    assign w_a[30] = a30;
    assign w_a[31] = a31;

    // Outputs are the register array itself, no extra staging
    assign b0  = arr_q[0];
    assign b1  = arr_q[1];
    assign b2  = arr_q[2];
    assign b3  = arr_q[3];
    assign b4  = arr_q[4];
    assign b5  = arr_q[5];
    assign b6  = arr_q[6];
    assign b7  = arr_q[7];
    assign b8  = arr_q[8];
    assign b9  = arr_q[9];
    assign b10 = arr_q[10];
    assign b11 = arr_q[11];
    assign b12 = arr_q[12];
    assign b13 = arr_q[13];
    assign b14 = arr_q[14];
    assign b15 = arr_q[15];
    assign b16 = arr_q[16];
    assign b17 = arr_q[17];
    assign b18 = arr_q[18];
    assign b19 = arr_q[19];
    assign b20 = arr_q[20];
    assign b21 = arr_q[21];
    assign b22 = arr_q[22];
    assign b23 = arr_q[23];
    assign b24 = arr_q[24];
    assign b25 = arr_q[25];
    assign b26 = arr_q[26];
    assign b27 = arr_q[27];
    assign b28 = arr_q[28];
    assign b29 = arr_q[29];
    assign b30 = arr_q[30];
    assign b31 = arr_q[31];

    // The index never exceeds lim-1 <= 30, so i+1 cannot wrap
    assign w_ip1  = i_q + 5'd1;
    assign w_last = lim_q - 5'd1;
    assign w_lo   = arr_q[i_q];
    assign w_hi   = arr_q[w_ip1];
    // Strictly greater: equal neighbours stay in place
    assign w_swap = (w_lo > w_hi);

    // Next-state logic: load on start, one compare-and-swap per SORT cycle
    always_comb begin
        state_d = state_q;
        arr_d   = arr_q;
        i_d     = i_q;
        lim_d   = lim_q;
        sw_d    = sw_q;

        case (state_q)
            ST_INI: begin
                if (start) begin
                    arr_d   = w_a;
                    i_d     = 5'd0;
                    lim_d   = C_LIM_INIT;
                    sw_d    = 1'b0;
                    state_d = ST_SORT;
                end
            end

            ST_SORT: begin
                if (w_swap) begin
                    arr_d[i_q]   = w_hi;
                    arr_d[w_ip1] = w_lo;
                end
                if (i_q < w_last) begin
                    i_d  = w_ip1;
                    sw_d = sw_q | w_swap;
                end else if ((sw_q || w_swap) && (lim_q > 5'd1)) begin
                    // Largest remaining value has bubbled to lim; shrink the pass
                    lim_d = w_last;
                    i_d   = 5'd0;
                    sw_d  = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // ack returns to idle; the sorted array is kept on the outputs
                if (ack) begin
                    state_d = ST_INI;
                end
            end

            default: begin
                state_d = ST_INI;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INI;
            for (int k = 0; k < 32; k++) begin
                arr_q[k] <= 7'd0;
            end
            i_q   <= 5'd0;
            lim_q <= C_LIM_INIT;
            sw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arr_q   <= arr_d;
            i_q     <= i_d;
            lim_q   <= lim_d;
            sw_q    <= sw_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort
//  Description : Self-checking bench for the 32-entry bubble sorter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sort;

    localparam logic [1:0] S_INI  = 2'd0;
    localparam logic [1:0] S_SORT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ack;
    logic [6:0] a_drv [32];
    wire  [6:0] b_mon [32];

    int checks = 0;
    int errors = 0;

    logic [223:0] exp_sorted;
    int           exp_cyc;

    always #5 clk = ~clk;

    sort dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack),
        .a0(a_drv[0]),   .a1(a_drv[1]),   .a2(a_drv[2]),   .a3(a_drv[3]),
        .a4(a_drv[4]),   .a5(a_drv[5]),   .a6(a_drv[6]),   .a7(a_drv[7]),
        .a8(a_drv[8]),   .a9(a_drv[9]),   .a10(a_drv[10]), .a11(a_drv[11]),
        .a12(a_drv[12]), .a13(a_drv[13]), .a14(a_drv[14]), .a15(a_drv[15]),
        .a16(a_drv[16]), .a17(a_drv[17]), .a18(a_drv[18]), .a19(a_drv[19]),
        .a20(a_drv[20]), .a21(a_drv[21]), .a22(a_drv[22]), .a23(a_drv[23]),
        .a24(a_drv[24]), .a25(a_drv[25]), .a26(a_drv[26]), .a27(a_drv[27]),
        .a28(a_drv[28]), .a29(a_drv[29]), .a30(a_drv[30]), .a31(a_drv[31]),
        .b0(b_mon[0]),   .b1(b_mon[1]),   .b2(b_mon[2]),   .b3(b_mon[3]),
        .b4(b_mon[4]),   .b5(b_mon[5]),   .b6(b_mon[6]),   .b7(b_mon[7]),
        .b8(b_mon[8]),   .b9(b_mon[9]),   .b10(b_mon[10]), .b11(b_mon[11]),
        .b12(b_mon[12]), .b13(b_mon[13]), .b14(b_mon[14]), .b15(b_mon[15]),
        .b16(b_mon[16]), .b17(b_mon[17]), .b18(b_mon[18]), .b19(b_mon[19]),
        .b20(b_mon[20]), .b21(b_mon[21]), .b22(b_mon[22]), .b23(b_mon[23]),
        .b24(b_mon[24]), .b25(b_mon[25]), .b26(b_mon[26]), .b27(b_mon[27]),
        .b28(b_mon[28]), .b29(b_mon[29]), .b30(b_mon[30]), .b31(b_mon[31])
    );

    function automatic logic [223:0] pack_b();
        logic [223:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[k*7 +: 7] = b_mon[k];
        return r;
    endfunction

    function automatic logic [223:0] pack_a();
        logic [223:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[k*7 +: 7] = a_drv[k];
        return r;
    endfunction

    function automatic logic [255:0] cur_state();
        return 256'(dut.state_q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sorted order from a queue sort; cycle count from the number
    // of bubble passes, which is one more than the largest count of greater
    // values preceding any element, capped at 31 passes of length 31,30,...
    task automatic model();
        int q[$];
        int maxinv;
        int inv;
        int np;
        q = {};
        maxinv = 0;
        for (int k = 0; k < 32; k++) begin
            q.push_back(int'(a_drv[k]));
            inv = 0;
            for (int j = 0; j < k; j++) if (a_drv[j] > a_drv[k]) inv++;
            if (inv > maxinv) maxinv = inv;
        end
        q.sort();
        exp_sorted = '0;
        for (int k = 0; k < 32; k++) exp_sorted[k*7 +: 7] = 7'(q[k]);
        np = (maxinv + 1 > 31) ? 31 : maxinv + 1;
        exp_cyc = 0;
        for (int p = 0; p < np; p++) exp_cyc += 31 - p;
    endtask

    // Start a sort on the current a_drv, optionally disturbing the inputs,
    // start and ack while sorting, and wait for DONE
    task automatic run_sort(input string tag, input bit mess, output int cyc);
        logic [223:0] raw;
        model();
        raw   = pack_a();
        start = 1'b1;
        tick();
        if (!mess) start = 1'b0;
        chk({tag, "_load"}, 256'(pack_b()), 256'(raw));
        if (mess) begin
            ack = 1'b1;
            for (int k = 0; k < 32; k++) a_drv[k] = 7'($urandom_range(0, 127));
        end
        cyc = 0;
        while (dut.state_q != S_DONE && cyc < 600) begin
            tick();
            cyc++;
        end
        start = 1'b0;
        ack   = 1'b0;
        chk({tag, "_cycles"}, 256'(cyc), 256'(exp_cyc));
        chk({tag, "_sorted"}, 256'(pack_b()), 256'(exp_sorted));
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    int cyc;
    int mix[32] = '{30,22,23,21,13,14,16,12,20,19,28,17,27,24,18,25,
                    26,16,9,11,6,12,31,7,8,10,5,4,3,2,1,0};
    int mix_exp[32] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,12,13,14,
                        16,16,17,18,19,20,21,22,23,24,25,26,27,28,30,31};
    logic [223:0] lit;
    logic [223:0] held;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        for (int k = 0; k < 32; k++) a_drv[k] = 7'($urandom_range(1, 127));

        // Reset state
        repeat (3) tick();
        chk("reset_b", 256'(pack_b()), 256'(0));
        chk("reset_state", cur_state(), 256'(S_INI));
        reset = 1'b1;
        repeat (4) tick();
        chk("idle_b", 256'(pack_b()), 256'(0));
        chk("idle_state", cur_state(), 256'(S_INI));

        // Mixed vector with duplicates
        for (int k = 0; k < 32; k++) a_drv[k] = 7'(mix[k]);
        run_sort("mixed", 1'b0, cyc);
        lit = '0;
        for (int k = 0; k < 32; k++) lit[k*7 +: 7] = 7'(mix_exp[k]);
        chk("mixed_literal", 256'(pack_b()), 256'(lit));
        repeat (5) tick();
        chk("hold_b", 256'(pack_b()), 256'(lit));
        chk("hold_state", cur_state(), 256'(S_DONE));
        do_ack();
        chk("ack_state", cur_state(), 256'(S_INI));
        chk("ack_b", 256'(pack_b()), 256'(lit));

        // Already sorted
        for (int k = 0; k < 32; k++) a_drv[k] = 7'(k);
        run_sort("ascending", 1'b0, cyc);
        chk("ascending_31", 256'(cyc), 256'(31));
        do_ack();

        // Reverse order: worst case
        for (int k = 0; k < 32; k++) a_drv[k] = 7'(31 - k);
        run_sort("reverse", 1'b0, cyc);
        chk("reverse_496", 256'(cyc), 256'(496));
        do_ack();

        // All equal at the top of the range
        for (int k = 0; k < 32; k++) a_drv[k] = 7'd127;
        run_sort("equal127", 1'b0, cyc);
        chk("equal127_31", 256'(cyc), 256'(31));
        do_ack();

        // start held, ack pulsed and inputs changed during SORT
        for (int k = 0; k < 32; k++) a_drv[k] = 7'($urandom_range(0, 127));
        run_sort("disturbed", 1'b1, cyc);

        // DONE with start and ack together: only ack acts
        held  = pack_b();
        for (int k = 0; k < 32; k++) a_drv[k] = 7'($urandom_range(0, 127));
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        chk("both_state", cur_state(), 256'(S_INI));
        chk("both_b", 256'(pack_b()), 256'(held));
        run_sort("resort", 1'b0, cyc);
        do_ack();

        // Reset in the middle of a sort
        for (int k = 0; k < 32; k++) a_drv[k] = 7'(120 - 3 * k);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        chk("midsort_state", cur_state(), 256'(S_SORT));
        #2 reset = 1'b0;
        #1;
        chk("abort_b", 256'(pack_b()), 256'(0));
        chk("abort_state", cur_state(), 256'(S_INI));
        repeat (2) tick();
        reset = 1'b1;
        tick();
        for (int k = 0; k < 32; k++) a_drv[k] = 7'($urandom_range(0, 127));
        run_sort("after_reset", 1'b0, cyc);
        do_ack();

        // Random vectors, some with a narrow value range to force duplicates
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 32; k++)
                a_drv[k] = (n % 2 == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(60, 67));
            run_sort($sformatf("random%0d", n), 1'b0, cyc);
            do_ack();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
